// File: rtl/aes_pkg.sv
// AES byte-substitution constants and lookup helpers shared by the SubBytes engine.
// Inverse table and lookup exist only when AES_SBOX_INV_EN is defined.
package aes_pkg;

  localparam int AES_BYTES = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SBOX_INV_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction
`endif

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // byte 0 sits in the most significant byte of the 128-bit state
  function automatic logic [6:0] byte_lsb(input int idx);
    return 7'(8 * (AES_BYTES - 1 - idx));
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; dec selects the inverse table when AES_SBOX_INV_EN is defined.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       dec,
  output logic [7:0] dout
);

`ifdef AES_SBOX_INV_EN
  assign dout = dec ? sbox_inv(din) : sbox_fwd(din);
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign dout = sbox_fwd(din);
`endif

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes engine: LANES bytes substituted per clock, valid/ready on both sides.
// AES_SBOX_INV_EN adds the in_dec port and per-block inverse substitution.
//
// state | meaning
// IDLE  | no block held, ready to accept
// RUN   | substituting chunk cnt; fin marks all chunks done, result moves to output next edge
// DONE  | out_valid high, result held until out_ready
module aes_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_SBOX_INV_EN
  input  logic         in_dec,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_seq: LANES=%0d must be 1, 2, 4, 8 or 16", LANES);
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_q, fin_d;
  logic          dec_q, dec_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  out_q, out_d;
  logic [127:0]  sub_state;
  logic          dec_in;
  logic          accept;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

`ifdef AES_SBOX_INV_EN
  assign dec_in = in_dec;
`else
  assign dec_in = 1'b0;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .din  (lane_in[g]),
      .dec  (dec_q),
      .dout (lane_out[g])
    );
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[byte_lsb(int'(cnt_q) * LANES + l) +: 8];
    end
  end

  always_comb begin
    sub_state = work_q;
    for (int l = 0; l < LANES; l++) begin
      sub_state[byte_lsb(int'(cnt_q) * LANES + l) +: 8] = lane_out[l];
    end
  end

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fin_d       = fin_q;
    dec_d       = dec_q;
    out_valid_d = out_valid_q;
    work_d      = work_q;
    out_d       = out_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (!fin_q) begin
          if (cnt_q == CNT_LAST) begin
            fin_d = 1'b1;
            // without the output register the last chunk stays raw and is substituted on the way out
            if (OUT_REG != 0) work_d = sub_state;
          end else begin
            work_d = sub_state;
            cnt_d  = cnt_q + CW'(1);
          end
        end else begin
          out_d       = work_q;
          out_valid_d = 1'b1;
          fin_d       = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      work_d  = in_state;
      dec_d   = dec_in;
      cnt_d   = '0;
      fin_d   = 1'b0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
      work_q      <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fin_q       <= fin_d;
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      work_q      <= work_d;
      out_q       <= out_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    assign out_state = out_q;
  end else begin : g_out_bypass
    logic unused_out;
    assign unused_out = ^out_q;
    assign out_state  = out_valid_q ? sub_state : '0;
  end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq; S-box reference derived from GF(2^8) inversion + affine map.
module tb_aes_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_state;
`ifdef AES_SBOX_INV_EN
  logic         in_dec;
`endif

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] out_state;
  logic         in_valid1, in_ready1, out_valid1, busy1;
  logic [127:0] out_state1;
  logic         in_valid16, in_ready16, out_valid16, busy16;
  logic [127:0] out_state16;
  logic         out_ready_aux;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_ref  [256];
  logic [7:0] isb_ref [256];

  always #5 clk = ~clk;

  aes_subbytes_seq #(.LANES(4), .OUT_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef AES_SBOX_INV_EN
    .in_dec(in_dec),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  aes_subbytes_seq #(.LANES(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state),
`ifdef AES_SBOX_INV_EN
    .in_dec(in_dec),
`endif
    .out_valid(out_valid1), .out_ready(out_ready_aux), .out_state(out_state1), .busy(busy1)
  );

  aes_subbytes_seq #(.LANES(16), .OUT_REG(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_state(in_state),
`ifdef AES_SBOX_INV_EN
    .in_dec(in_dec),
`endif
    .out_valid(out_valid16), .out_ready(out_ready_aux), .out_state(out_state16), .busy(busy16)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, b);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s, input logic dec);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = s[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = dec ? isb_ref[b] : sb_ref[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start4(input string tag, input logic [127:0] st, input logic dec);
    chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
    in_state = st;
`ifdef AES_SBOX_INV_EN
    in_dec = dec;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rand128();
`ifdef AES_SBOX_INV_EN
    in_dec = ~dec;
`endif
    chk({tag, "_busy"}, 128'(busy), 128'(1));
  endtask

  task automatic wait4(input string tag, input logic [127:0] exp, input int k0, output logic [127:0] res);
    int k;
    k = k0;
    while (out_valid !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, 128'(k), 128'(5));
    res = out_state;
    chk({tag, "_data"}, res, exp);
  endtask

  task automatic retire4(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 128'(out_valid), 128'(0));
  endtask

  task automatic send4(input string tag, input logic [127:0] st, input logic dec,
                       input logic [127:0] exp, output logic [127:0] res);
    start4(tag, st, dec);
    wait4(tag, exp, 0, res);
    retire4(tag);
  endtask

  task automatic run_aux(input int sel, input string tag, input logic [127:0] st,
                         input logic [127:0] exp, input int exp_lat);
    int k;
    chk({tag, "_rdy"}, 128'((sel == 1) ? in_ready1 : in_ready16), 128'(1));
    in_state = st;
`ifdef AES_SBOX_INV_EN
    in_dec = 1'b0;
`endif
    if (sel == 1) in_valid1 = 1'b1; else in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid16 = 1'b0;
    in_state = rand128();
    chk({tag, "_busy"}, 128'((sel == 1) ? busy1 : busy16), 128'(1));
    k = 0;
    while (((sel == 1) ? out_valid1 : out_valid16) !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, 128'(k), 128'(exp_lat));
    chk({tag, "_data"}, (sel == 1) ? out_state1 : out_state16, exp);
    out_ready_aux = 1'b1;
    @(posedge clk); #1;
    out_ready_aux = 1'b0;
    chk({tag, "_drop"}, 128'((sel == 1) ? out_valid1 : out_valid16), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish within 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, st, a_exp, b_st, b_exp;
    logic [7:0]   spot_in [8];
    logic [7:0]   spot_out [8];
    int           pos;

    rst_n = 1'b0;
    in_valid = 1'b0; in_valid1 = 1'b0; in_valid16 = 1'b0;
    out_ready = 1'b0; out_ready_aux = 1'b0;
    in_state = '0;
`ifdef AES_SBOX_INV_EN
    in_dec = 1'b0;
`endif
    for (int i = 0; i < 256; i++) sb_ref[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) isb_ref[sb_ref[i]] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_out_state16", out_state16, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_ready_valid", 128'(out_valid), 128'(0));
    chk("spur_ready_busy", 128'(busy), 128'(0));
    out_ready = 1'b0;

    send4("t1_zero", 128'h0, 1'b0, {16{8'h63}}, res);

    send4("t2_l4", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
          128'hd42711aee0bf98f1b8b45de51e415230, res);
    run_aux(1, "t2_l1", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
            128'hd42711aee0bf98f1b8b45de51e415230, 17);
    run_aux(16, "t2_l16", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
            128'hd42711aee0bf98f1b8b45de51e415230, 2);

    spot_in  = '{8'h23, 8'h56, 8'ha3, 8'h4e, 8'h19, 8'hff, 8'hcc, 8'hdf};
    spot_out = '{8'h26, 8'hb1, 8'h0a, 8'h2f, 8'hd4, 8'h16, 8'h4b, 8'h9e};
    for (int k = 0; k < 8; k++) begin
      pos = (k * 5) % 16;
      st = rand128();
      st[127 - 8*pos -: 8] = spot_in[k];
      send4("t3_spot", st, 1'b0, sub_ref(st, 1'b0), res);
      chk("t3_byte", 128'(res[127 - 8*pos -: 8]), 128'(spot_out[k]));
    end

    for (int r = 0; r < 6; r++) begin
      st = rand128();
      send4("rand", st, 1'b0, sub_ref(st, 1'b0), res);
    end
    run_aux(1, "rand_l1", st, sub_ref(st, 1'b0), 17);
    run_aux(16, "rand_l16", st, sub_ref(st, 1'b0), 2);

    st = rand128();
    a_exp = sub_ref(st, 1'b0);
    start4("t4a", st, 1'b0);
    wait4("t4a", a_exp, 0, res);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 128'(out_valid), 128'(1));
      chk("t4_hold_state", out_state, a_exp);
      chk("t4_hold_in_ready", 128'(in_ready), 128'(0));
    end
    b_st = rand128();
    b_exp = sub_ref(b_st, 1'b0);
    in_state = b_st;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t4_b2b_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_state = rand128();
    chk("t4_b2b_drop", 128'(out_valid), 128'(0));
    chk("t4_b2b_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    chk("t4_run_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    wait4("t4b", b_exp, 1, res);
    retire4("t4b");

    st = rand128();
    start4("t5", st, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    st = rand128();
    send4("t5_after", st, 1'b0, sub_ref(st, 1'b0), res);

`ifdef AES_SBOX_INV_EN
    send4("t6_inv", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
          128'h193de3bea0f4e22b9ac68d2ae9f84808, res);
    send4("t6_63", {16{8'h63}}, 1'b1, 128'h0, res);
    for (int r = 0; r < 4; r++) begin
      st = rand128();
      send4("t6_rand", st, r[0], sub_ref(st, r[0]), res);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
